// File: rtl/lcd_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// lcd_share_arbiter_if
// Bundles the requester-side inputs and the display-side outputs of the LCD
// sharing arbiter.
//   req   : per-requester display request (level)
//   data  : packed requester words, requester k at [k*DW +: DW]
//   LCD   : registered display word
//   gnt   : one-hot current owner, zero when idle
//   ack   : one-cycle pulse on the cycle a grant begins
//   owner : index of the current or most recent owner
//   busy  : high while a grant is held
// The master modport drives requests; the slave modport is the arbiter.
// -----------------------------------------------------------------------------
interface lcd_share_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 64
);
   localparam int OW = $clog2(NREQ);

   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] data;
   logic [DW-1:0]      LCD;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    ack;
   logic [OW-1:0]      owner;
   logic               busy;

   modport master (
      output req, data,
      input  LCD, gnt, ack, owner, busy
   );

   modport slave (
      input  req, data,
      output LCD, gnt, ack, owner, busy
   );
endinterface

// File: rtl/lcd_share_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_share_arbiter
// Shares one DW-bit LCD display word between NREQ requesters using
// round-robin arbitration. A grant is held for at least HOLD cycles so the
// displayed value stays readable; while the owner keeps its request high the
// display follows its data live, otherwise the display is frozen.
//
// Ports:
//   clk_2   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of lcd_share_arbiter_if (req/data in,
//             LCD/gnt/ack/owner/busy out, all outputs registered)
//
// Parameters:
//   NREQ : number of requesters (2..8)
//   DW   : display word width
//   HOLD : minimum grant length in cycles (>= 1)
// -----------------------------------------------------------------------------
module lcd_share_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 64,
   parameter int HOLD = 8
) (
   input  logic               clk_2,
   input  logic               reset_n,
   lcd_share_arbiter_if.slave bus
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(HOLD + 1);
   localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Index (base + off) wrapped into 0..NREQ-1; NREQ need not be a power of two.
   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
      int sum;
      sum = (int'(base) + off) % NREQ;
      return PW'(sum);
   endfunction

   // Round-robin pick: returns {found, index} of the first requester at or
   // after p. The loop runs backwards so the nearest requester is written last.
   function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
      logic [PW:0]   res;
      logic [PW-1:0] idx;
      res = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = wrap_idx(p, i);
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q,   ptr_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [NREQ-1:0] gnt_q,   gnt_d;
   logic [NREQ-1:0] ack_q,   ack_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [DW-1:0]   lcd_q,   lcd_d;
   logic            busy_q,  busy_d;

   logic [DW-1:0]   words_s [NREQ];
   logic [PW:0]     pick_s;
   logic            pick_found_s;
   logic [PW-1:0]   pick_idx_s;
   logic            start_s;

   // Unpack the requester words so they can be selected by index.
   for (genvar k = 0; k < NREQ; k++) begin : g_words
      assign words_s[k] = bus.data[k*DW +: DW];
   end

   // Round-robin candidate; since ptr sits just past the last owner, that
   // owner is naturally searched last.
   always_comb begin
      pick_s       = rr_pick(bus.req, ptr_q);
      pick_found_s = pick_s[PW];
      pick_idx_s   = pick_s[PW-1:0];
   end

   // Next-state and next-output logic for the IDLE/HOLD machine.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      owner_d = owner_q;
      lcd_d   = lcd_q;
      busy_d  = busy_q;
      start_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_found_s) begin
               start_s = 1'b1;
            end else begin
               gnt_d  = '0;
               busy_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (cnt_q != '0) begin
               // Minimum hold still running: other requesters wait, the
               // owner's data is shown live only while it keeps asking.
               cnt_d = cnt_q - CW'(1);
               if (bus.req[owner_q]) begin
                  lcd_d = words_s[owner_q];
               end else begin
                  lcd_d = lcd_q;
               end
            end else if (pick_found_s) begin
               // Back-to-back handover (or re-grant of a lone owner).
               start_s = 1'b1;
            end else begin
               // Nobody waiting: release, but keep LCD and owner visible.
               state_d = ST_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase

      if (start_s) begin
         state_d = ST_HOLD;
         gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
         ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
         owner_d = pick_idx_s;
         lcd_d   = words_s[pick_idx_s];
         cnt_d   = CNT_RELOAD;
         busy_d  = 1'b1;
         ptr_d   = wrap_idx(pick_idx_s, 1);
      end else begin
         state_d = state_d;
      end
   end

   // State and registered outputs; reset aborts any grant immediately.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         owner_q <= '0;
         lcd_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         owner_q <= owner_d;
         lcd_q   <= lcd_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.LCD   = lcd_q;
   assign bus.gnt   = gnt_q;
   assign bus.ack   = ack_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_lcd_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_share_arbiter
// Directed bench for lcd_share_arbiter: a vector table for the single
// requester flow, plus hand-written sequences for contention, live update,
// round-robin fairness, reset mid-grant and a HOLD=1 instance.
// -----------------------------------------------------------------------------
module tb_lcd_share_arbiter;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  gnt;
      logic [3:0]  ack;
      logic [1:0]  owner;
      logic [63:0] lcd;
      logic        busy;
   } vec_t;

   logic clk_2;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   logic [63:0] dw [4];
   vec_t        vecs [10];

   lcd_share_arbiter_if #(.NREQ(4), .DW(64)) bus  ();
   lcd_share_arbiter_if #(.NREQ(4), .DW(64)) bus1 ();

   lcd_share_arbiter #(.NREQ(4), .DW(64), .HOLD(8)) u_dut (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   lcd_share_arbiter #(.NREQ(4), .DW(64), .HOLD(1)) u_dut1 (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .bus     (bus1.slave)
   );

   initial clk_2 = 1'b0;
   always #5 clk_2 = ~clk_2;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_2);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                          input logic [1:0] o, input logic [63:0] l, input logic b);
      chk({tag, " gnt"},   64'(bus.gnt),   64'(g));
      chk({tag, " ack"},   64'(bus.ack),   64'(a));
      chk({tag, " owner"}, 64'(bus.owner), 64'(o));
      chk({tag, " LCD"},   bus.LCD,        l);
      chk({tag, " busy"},  64'(bus.busy),  64'(b));
   endtask

   task automatic apply_data();
      for (int k = 0; k < 4; k++) begin
         bus.data[k*64 +: 64]  = dw[k];
         bus1.data[k*64 +: 64] = dw[k];
      end
   endtask

   // Called just after an edge: pulse reset, release on the falling clock edge.
   task automatic do_reset();
      bus.req  = 4'b0000;
      bus1.req = 4'b0000;
      #1 reset_n = 1'b0;
      @(negedge clk_2);
      reset_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      dw[0] = 64'h0000_0000_0000_00A0;
      dw[1] = 64'h0000_0000_0000_00B1;
      dw[2] = 64'h0000_0000_DEAD_BEEF;
      dw[3] = 64'h0000_0000_0000_00C3;

      // Single requester 2: grant, drop req at cycle 3, hold runs 8 cycles.
      vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 64'hDEAD_BEEF, 1'b1};
      vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b1};
      vecs[2] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b1};
      vecs[3] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b1};
      vecs[4] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b1};
      vecs[5] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b1};
      vecs[6] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b1};
      vecs[7] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b1};
      vecs[8] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b0};
      vecs[9] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 64'hDEAD_BEEF, 1'b0};

      reset_n  = 1'b1;
      bus.req  = 4'b0000;
      bus1.req = 4'b0000;
      apply_data();
      #2 reset_n = 1'b0;
      #1;
      chk_out("reset", 4'b0000, 4'b0000, 2'd0, 64'h0, 1'b0);
      @(negedge clk_2);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         bus.req = vecs[i].req;
         tick();
         chk_out($sformatf("single[%0d]", i), vecs[i].gnt, vecs[i].ack,
                 vecs[i].owner, vecs[i].lcd, vecs[i].busy);
      end

      // Contention: all four request, expect 0,1,2,3,0 every 8 cycles.
      do_reset();
      bus.req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 8; c++) begin
            tick();
            chk_out($sformatf("contend g%0d c%0d", g, c), 4'(1 << (g % 4)),
                    (c == 0) ? 4'(1 << (g % 4)) : 4'b0000, 2'(g % 4), dw[g % 4], 1'b1);
         end
      end

      // Live update from a counter source, then freeze after req[1] drops.
      do_reset();
      bus.req = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         bus.data[64 +: 64] = 64'h0C + 64'(i);
         tick();
         chk_out($sformatf("live[%0d]", i), 4'b0010, (i == 0) ? 4'b0010 : 4'b0000,
                 2'd1, 64'h0C + 64'(i), 1'b1);
      end
      bus.req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         bus.data[64 +: 64] = 64'h11 + 64'(i);
         tick();
         chk_out($sformatf("frozen[%0d]", i), 4'b0010, 4'b0000, 2'd1, 64'h10, 1'b1);
      end
      tick();
      chk_out("live release", 4'b0000, 4'b0000, 2'd1, 64'h10, 1'b0);
      apply_data();

      // Fairness: lone requester 3 is re-granted, then 0 wins over 3.
      do_reset();
      bus.req = 4'b1000;
      tick();
      chk_out("rr grant3", 4'b1000, 4'b1000, 2'd3, dw[3], 1'b1);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_out($sformatf("rr hold3a[%0d]", i), 4'b1000, 4'b0000, 2'd3, dw[3], 1'b1);
      end
      tick();
      chk_out("rr regrant3", 4'b1000, 4'b1000, 2'd3, dw[3], 1'b1);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_out($sformatf("rr hold3b[%0d]", i), 4'b1000, 4'b0000, 2'd3, dw[3], 1'b1);
      end
      bus.req = 4'b1001;
      tick();
      chk_out("rr to0", 4'b0001, 4'b0001, 2'd0, dw[0], 1'b1);

      // Reset while holding with cnt=4; requester 3 also asks after release
      // so a pointer that survived reset would pick 3 instead of 1.
      do_reset();
      bus.req = 4'b0100;
      for (int i = 0; i < 4; i++) tick();
      chk_out("pre-reset", 4'b0100, 4'b0000, 2'd2, dw[2], 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk_out("mid reset", 4'b0000, 4'b0000, 2'd0, 64'h0, 1'b0);
      bus.req = 4'b1010;
      @(negedge clk_2);
      reset_n = 1'b1;
      tick();
      chk_out("post reset", 4'b0010, 4'b0010, 2'd1, dw[1], 1'b1);

      // HOLD=1 instance: grant alternates 0/2 every cycle.
      bus.req  = 4'b0000;
      bus1.req = 4'b0101;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("hold1[%0d] gnt", i), 64'(bus1.gnt), (i % 2 == 0) ? 64'h1 : 64'h4);
         chk($sformatf("hold1[%0d] ack", i), 64'(bus1.ack), (i % 2 == 0) ? 64'h1 : 64'h4);
         chk($sformatf("hold1[%0d] LCD", i), bus1.LCD, (i % 2 == 0) ? dw[0] : dw[2]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
